// File: rtl/ldtu_hamm_decoder.sv
// ldtu_hamm_decoder
//   Read side of the Hamming storage FIFO. Pulls Hamming(38,32) codewords
//   from the output FIFO and computes the 6-bit syndrome. It corrects
//   single-bit errors and presents 32-bit words on a valid/ready port
//   through a 2-entry output buffer. It also keeps saturating
//   corrected/uncorrectable counts and a sticky SEU flag for slow control.
//
// Ports
//   CLK          in   clock, all logic on posedge
//   rst_b        in   asynchronous active-low reset
//   fifo_empty   in   FIFO empty flag
//   fifo_data    in   FIFO registered read data (codeword)
//   fifo_decode  in   fifo_data holds a freshly read word this cycle
//   fifo_read    out  read request to the FIFO
//   out_data     out  corrected data word (0 while out_valid=0)
//   out_status   out  00 clean, 01 corrected, 10 uncorrectable
//   out_valid    out  head of output buffer is valid
//   out_ready    in   downstream accepts when out_valid && out_ready
//   cnt_clear    in   synchronous clear of counters and seu_flag
//   cnt_corr     out  saturating count of corrected words
//   cnt_unc      out  saturating count of uncorrectable words
//   seu_flag     out  sticky: any non-zero syndrome captured
`timescale 1ns/1ps
module ldtu_hamm_decoder #(
  parameter int Nbits_ham  = 38,
  parameter int Nbits_data = 32,
  parameter int CntW_corr  = 16,
  parameter int CntW_unc   = 8
) (
  input  logic                  CLK,
  input  logic                  rst_b,
  input  logic                  fifo_empty,
  input  logic [Nbits_ham-1:0]  fifo_data,
  input  logic                  fifo_decode,
  output logic                  fifo_read,
  output logic [Nbits_data-1:0] out_data,
  output logic [1:0]            out_status,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  cnt_clear,
  output logic [CntW_corr-1:0]  cnt_corr,
  output logic [CntW_unc-1:0]   cnt_unc,
  output logic                  seu_flag
);

  localparam int SynW = 6;

  localparam logic [1:0] ST_CLEAN = 2'b00;
  localparam logic [1:0] ST_CORR  = 2'b01;
  localparam logic [1:0] ST_UNC   = 2'b10;

  // Syndrome: XOR of the Hamming positions (bit index + 1) of all set bits.
  function automatic logic [SynW-1:0] calc_syndrome(input logic [Nbits_ham-1:0] cw);
    logic [SynW-1:0] s;
    s = '0;
    for (int i = 0; i < Nbits_ham; i++) begin
      if (cw[i]) s = s ^ SynW'(i + 1);
    end
    return s;
  endfunction

  // Inverts the bit at position s; syndromes beyond the codeword match nothing.
  function automatic logic [Nbits_ham-1:0] apply_fix(input logic [Nbits_ham-1:0] cw,
                                                     input logic [SynW-1:0]      s);
    logic [Nbits_ham-1:0] f;
    f = cw;
    for (int i = 0; i < Nbits_ham; i++) begin
      if (s == SynW'(i + 1)) f[i] = ~cw[i];
    end
    return f;
  endfunction

  // Data bits occupy every non-power-of-two position, in ascending order.
  function automatic logic [Nbits_data-1:0] extract_data(input logic [Nbits_ham-1:0] cw);
    logic [Nbits_data-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 0; i < Nbits_ham; i++) begin
      if (((i + 1) & i) != 0) begin
        if (j < Nbits_data) d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [1:0] classify(input logic [SynW-1:0] s);
    if (s == '0)                    return ST_CLEAN;
    else if (s <= SynW'(Nbits_ham)) return ST_CORR;
    else                            return ST_UNC;
  endfunction

  function automatic logic [CntW_corr-1:0] sat_inc_corr(input logic [CntW_corr-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [CntW_unc-1:0] sat_inc_unc(input logic [CntW_unc-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [SynW-1:0]       w_syn;
  logic [1:0]            w_stat;
  logic [Nbits_data-1:0] w_data;
  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_credits;

  logic [Nbits_data-1:0] r_bdata [2];
  logic [1:0]            r_bstat [2];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic                  r_run;

  // p0: combinational decode of the word arriving from the FIFO
  assign w_syn  = calc_syndrome(fifo_data);
  assign w_stat = classify(w_syn);
  assign w_data = extract_data(apply_fix(fifo_data, w_syn));

  assign out_valid  = (r_occ != 2'd0);
  assign out_data   = out_valid ? r_bdata[r_rp] : '0;
  assign out_status = out_valid ? r_bstat[r_rp] : ST_CLEAN;

  assign w_pop  = out_valid && out_ready;
  // A full buffer still accepts a word when its head leaves in the same cycle.
  assign w_push = fifo_decode && ((r_occ != 2'd2) || w_pop);

  // Slots committed after this cycle: stored + arriving - leaving.
  // Issuing a read only while this is below 2 guarantees a free slot on arrival.
  assign w_credits = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  // r_run keeps the request low during and straight out of reset.
  assign fifo_read = r_run && !fifo_empty && (w_credits < 3'd2);

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= fifo_read;
    end
  end

  // p1: output buffer, FIFO ordered via write/read pointers
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_bdata[r_wp] <= w_data;
      r_bstat[r_wp] <= w_stat;
    end
  end

  // Counters and SEU flag follow captured words; clear wins over a same-cycle event.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      cnt_corr <= '0;
      cnt_unc  <= '0;
      seu_flag <= 1'b0;
    end else if (cnt_clear) begin
      cnt_corr <= '0;
      cnt_unc  <= '0;
      seu_flag <= 1'b0;
    end else if (w_push) begin
      if (w_stat == ST_CORR) cnt_corr <= sat_inc_corr(cnt_corr);
      if (w_stat == ST_UNC)  cnt_unc  <= sat_inc_unc(cnt_unc);
      if (w_syn != '0)       seu_flag <= 1'b1;
    end
  end

endmodule
